// File: rtl/tank_pkg.sv
// Shared definitions for the tank game datapath blocks.
//   - one-hot direction codes used by tank and bullet logic
//   - visible screen size
//   - bullet FSM state type
//   - box_on_screen(): true when a square box of edge `size` with top-left (x,y)
//     lies fully inside the visible area
package tank_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    FLY,
    COOLDOWN
  } bullet_state_t;

  // Far edges are widened to 12 bits so x+size cannot wrap back into range.
  function automatic logic box_on_screen(input logic signed [10:0] x,
                                         input logic signed [10:0] y,
                                         input int unsigned       size);
    logic signed [11:0] x_end;
    logic signed [11:0] y_end;
    x_end = 12'(x) + $signed(12'(size));
    y_end = 12'(y) + $signed(12'(size));
    return (x >= 11'sd0) && (y >= 11'sd0) &&
           (x_end <= $signed(12'(SCREEN_W))) &&
           (y_end <= $signed(12'(SCREEN_H)));
  endfunction

endpackage

// File: rtl/bullet_spawn_calc.sv
// Combinational muzzle-position calculator.
// Ports:
//   tank_x, tank_y  in  10  tank top-left, px
//   tank_dir        in  4   one-hot facing direction
//   spawn_x/y       out 11  signed bullet top-left at the muzzle
//   spawn_ok        out 1   direction is one-hot and the spawn box is fully on-screen
module bullet_spawn_calc
  import tank_pkg::*;
#(
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 8
) (
  input  logic [9:0]         tank_x,
  input  logic [9:0]         tank_y,
  input  logic [3:0]         tank_dir,
  output logic signed [10:0] spawn_x,
  output logic signed [10:0] spawn_y,
  output logic               spawn_ok
);

  // Centres the bullet across the tank edge it leaves from.
  localparam logic signed [10:0] OFS = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic signed [10:0] TS  = 11'(TANK_SIZE);
  localparam logic signed [10:0] BS  = 11'(BULLET_SIZE);

  logic signed [10:0] tx;
  logic signed [10:0] ty;

  assign tx = $signed({1'b0, tank_x});
  assign ty = $signed({1'b0, tank_y});

  always_comb begin
    spawn_x = tx + OFS;
    spawn_y = ty + OFS;
    case (tank_dir)
      DIR_UP:    spawn_y = ty - BS;
      DIR_DOWN:  spawn_y = ty + TS;
      DIR_LEFT:  spawn_x = tx - BS;
      DIR_RIGHT: spawn_x = tx + TS;
      default: ;
    endcase
    spawn_ok = $onehot(tank_dir) && box_on_screen(spawn_x, spawn_y, BULLET_SIZE);
  end

endmodule

// File: rtl/bullet_ctrl.sv
// Per-tank bullet controller feeding the sprite renderer.
// Spawns a bullet at the muzzle on a fire press, steps it every frame_tick,
// retires it on screen exit or hit, then holds off new shots for a cooldown.
// Ports:
//   vga_clk        in   1   pixel clock
//   reset          in   1   synchronous, active-high
//   frame_tick     in   1   one pulse per frame
//   fire           in   1   fire button level, rising edge requests a shot
//   tank_x/y       in   10  tank top-left, px
//   tank_dir       in   4   one-hot tank direction
//   hit            in   1   collision pulse, honoured only in flight
//   bullet_x/y     out  10  bullet top-left, PARK when inactive
//   bullet_dir     out  4   direction latched at spawn, 0 when inactive
//   bullet_active  out  1   bullet in flight
//   fire_ack       out  1   pulse on the spawn cycle
// All outputs come straight from registers.
module bullet_ctrl
  import tank_pkg::bullet_state_t, tank_pkg::IDLE, tank_pkg::FLY,
         tank_pkg::DIR_UP, tank_pkg::DIR_DOWN, tank_pkg::DIR_LEFT,
         tank_pkg::DIR_RIGHT, tank_pkg::box_on_screen;
#(
  parameter int         TANK_SIZE   = 32,
  parameter int         BULLET_SIZE = 8,
  parameter int         SPEED       = 4,
  parameter int         COOLDOWN    = 16,
  parameter logic [9:0] PARK        = 10'h3F0
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] tank_x,
  input  logic [9:0] tank_y,
  input  logic [3:0] tank_dir,
  input  logic       hit,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [3:0] bullet_dir,
  output logic       bullet_active,
  output logic       fire_ack
);

  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [10:0] STEP = 11'(SPEED);

  bullet_state_t      state_q, state_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic [3:0]         dir_q, dir_d;
  logic               act_q, act_d;
  logic               ack_q, ack_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fire_q;

  logic               fire_req;
  logic signed [10:0] spawn_x, spawn_y;
  logic               spawn_ok;
  logic signed [10:0] cur_x, cur_y, nxt_x, nxt_y;
  logic               retire;
  logic               unused_sign;

  bullet_spawn_calc #(
    .TANK_SIZE   (TANK_SIZE),
    .BULLET_SIZE (BULLET_SIZE)
  ) u_spawn (
    .tank_x   (tank_x),
    .tank_y   (tank_y),
    .tank_dir (tank_dir),
    .spawn_x  (spawn_x),
    .spawn_y  (spawn_y),
    .spawn_ok (spawn_ok)
  );

  // Sign bits are only needed for the bounds test inside the calculator.
  assign unused_sign = spawn_x[10] ^ spawn_y[10];

  assign fire_req = fire & ~fire_q;

  assign cur_x = $signed({1'b0, x_q});
  assign cur_y = $signed({1'b0, y_q});

  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    case (dir_q)
      DIR_UP:    nxt_y = cur_y - STEP;
      DIR_DOWN:  nxt_y = cur_y + STEP;
      DIR_LEFT:  nxt_x = cur_x - STEP;
      DIR_RIGHT: nxt_x = cur_x + STEP;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    act_d   = act_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    retire  = 1'b0;

    case (state_q)
      IDLE: begin
        // A rejected request is simply dropped; the edge is not remembered.
        if (fire_req && spawn_ok) begin
          state_d = FLY;
          x_d     = spawn_x[9:0];
          y_d     = spawn_y[9:0];
          dir_d   = tank_dir;
          act_d   = 1'b1;
          ack_d   = 1'b1;
        end
      end
      FLY: begin
        // hit takes precedence over a same-cycle frame step.
        if (hit) begin
          retire = 1'b1;
        end else if (frame_tick) begin
          if (box_on_screen(nxt_x, nxt_y, BULLET_SIZE)) begin
            x_d = nxt_x[9:0];
            y_d = nxt_y[9:0];
          end else begin
            retire = 1'b1;
          end
        end
      end
      // The COOLDOWN parameter shares its name with this state, so the
      // literal is reached through the package.
      tank_pkg::COOLDOWN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      state_d = tank_pkg::COOLDOWN;
      x_d     = PARK;
      y_d     = PARK;
      dir_d   = '0;
      act_d   = 1'b0;
      cnt_d   = CNT_W'(COOLDOWN);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= PARK;
      y_q     <= PARK;
      dir_q   <= '0;
      act_q   <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      // Preset high so a button held through reset is not seen as a press.
      fire_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      act_q   <= act_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire;
    end
  end

  assign bullet_x      = x_q;
  assign bullet_y      = y_q;
  assign bullet_dir    = dir_q;
  assign bullet_active = act_q;
  assign fire_ack      = ack_q;

endmodule

// File: tb/tb_bullet_ctrl.sv
module tb_bullet_ctrl;

  logic       vga_clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       fire;
  logic [9:0] tank_x;
  logic [9:0] tank_y;
  logic [3:0] tank_dir;
  logic       hit;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic [3:0] bullet_dir;
  logic       bullet_active;
  logic       fire_ack;

  typedef struct packed {
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] dir;
    logic       ack;
  } exp_t;

  exp_t q_exp[$];
  int   checks   = 0;
  int   failures = 0;
  int   ack_count = 0;
  logic count_acks = 1'b0;

  localparam logic [9:0] PARK = 10'h3F0;

  bullet_ctrl dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .tank_x        (tank_x),
    .tank_y        (tank_y),
    .tank_dir      (tank_dir),
    .hit           (hit),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_dir    (bullet_dir),
    .bullet_active (bullet_active),
    .fire_ack      (fire_ack)
  );

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) begin
    if (count_acks && fire_ack) ack_count++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic act, input logic [9:0] x, input logic [9:0] y,
                              input logic [3:0] dir, input logic ack);
    exp_t e;
    e.act = act; e.x = x; e.y = y; e.dir = dir; e.ack = ack;
    return e;
  endfunction

  function automatic exp_t parked();
    return mk(1'b0, PARK, PARK, 4'b0000, 1'b0);
  endfunction

  task automatic cycle();
    @(posedge vga_clk);
    #1;
  endtask

  // Push expectation for the cycle about to be clocked, then pop and compare.
  task automatic tick_expect(input string tag, input exp_t e);
    exp_t r;
    q_exp.push_back(e);
    cycle();
    if (q_exp.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      r = q_exp.pop_front();
      check_eq({tag, "_active"}, 32'(bullet_active), 32'(r.act));
      check_eq({tag, "_x"},      32'(bullet_x),      32'(r.x));
      check_eq({tag, "_y"},      32'(bullet_y),      32'(r.y));
      check_eq({tag, "_dir"},    32'(bullet_dir),    32'(r.dir));
      check_eq({tag, "_ack"},    32'(fire_ack),      32'(r.ack));
    end
  endtask

  task automatic frame();
    frame_tick = 1'b1; cycle();
    frame_tick = 1'b0; cycle();
  endtask

  task automatic frame_expect(input string tag, input exp_t e);
    frame_tick = 1'b1; tick_expect(tag, e);
    frame_tick = 1'b0; cycle();
  endtask

  task automatic wait_cooldown();
    for (int i = 0; i < 16; i++) frame();
    cycle();
  endtask

  task automatic press();
    fire = 1'b0; cycle();
    fire = 1'b1;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; fire = 1'b1; hit = 1'b0;
    tank_x = 10'd100; tank_y = 10'd200; tank_dir = 4'b0001;
    cycle();
    tick_expect("reset", parked());
    reset = 1'b0;
    tick_expect("fire_held_rst", parked());
    tick_expect("fire_held_rst2", parked());

    // Up shot and three steps.
    press();
    tick_expect("spawn_up", mk(1'b1, 10'd112, 10'd192, 4'b0001, 1'b1));
    for (int i = 1; i <= 3; i++)
      frame_expect("step_up", mk(1'b1, 10'd112, 10'(192 - 4*i), 4'b0001, 1'b0));
    hit = 1'b1;
    tick_expect("hit_retire", parked());
    hit = 1'b0;
    wait_cooldown();

    // Right shot at the screen edge, exits on first step.
    tank_x = 10'd600; tank_y = 10'd100; tank_dir = 4'b1000;
    press();
    tick_expect("spawn_right", mk(1'b1, 10'd632, 10'd112, 4'b1000, 1'b1));
    frame_tick = 1'b1;
    tick_expect("exit_right", parked());
    frame_tick = 1'b0;
    wait_cooldown();

    // Spawn box off the top: rejected.
    tank_x = 10'd100; tank_y = 10'd4; tank_dir = 4'b0001;
    press();
    tick_expect("reject_top", parked());
    tick_expect("reject_top2", parked());

    // Non one-hot direction: rejected.
    tank_y = 10'd200; tank_dir = 4'b0011;
    press();
    tick_expect("reject_dir", parked());

    // Hit and frame_tick together: no step, retire.
    tank_dir = 4'b0010;
    press();
    tick_expect("spawn_down", mk(1'b1, 10'd112, 10'd232, 4'b0010, 1'b1));
    hit = 1'b1; frame_tick = 1'b1;
    tick_expect("hit_and_tick", parked());
    hit = 1'b0; frame_tick = 1'b0;
    wait_cooldown();

    // hit in IDLE is ignored: a shot is still accepted right after.
    hit = 1'b1;
    tick_expect("hit_idle", parked());
    hit = 1'b0;
    tank_dir = 4'b0100;
    press();
    tick_expect("spawn_left_after_idle_hit", mk(1'b1, 10'd92, 10'd212, 4'b0100, 1'b1));
    frame_expect("step_left", mk(1'b1, 10'd88, 10'd212, 4'b0100, 1'b0));

    // Direction change and fire in flight are ignored; reset mid-flight.
    hit = 1'b1; cycle(); hit = 1'b0;
    wait_cooldown();
    tank_dir = 4'b0001;
    press();
    tick_expect("spawn_up2", mk(1'b1, 10'd112, 10'd192, 4'b0001, 1'b1));
    tank_dir = 4'b0100;
    frame_expect("dir_change_ignored", mk(1'b1, 10'd112, 10'd188, 4'b0001, 1'b0));
    press();
    tick_expect("fire_in_flight", mk(1'b1, 10'd112, 10'd188, 4'b0001, 1'b0));
    reset = 1'b1;
    tick_expect("reset_mid_flight", parked());
    reset = 1'b0;
    tick_expect("after_reset", parked());

    // Held fire over 40 frames yields exactly one shot.
    tank_x = 10'd100; tank_y = 10'd40; tank_dir = 4'b0001;
    count_acks = 1'b1;
    press();
    for (int i = 0; i < 40; i++) frame();
    count_acks = 1'b0;
    check_eq("held_fire_acks", 32'(ack_count), 32'd1);

    // Press during cooldown is dropped; press after cooldown shoots.
    press();
    tick_expect("spawn_cd", mk(1'b1, 10'd112, 10'd32, 4'b0001, 1'b1));
    for (int i = 1; i <= 8; i++)
      frame_expect("step_cd", mk(1'b1, 10'd112, 10'(32 - 4*i), 4'b0001, 1'b0));
    frame_expect("exit_top", parked());
    for (int i = 0; i < 10; i++) frame();
    press();
    tick_expect("press_in_cooldown", parked());
    for (int i = 0; i < 6; i++) frame();
    cycle();
    press();
    tick_expect("press_after_cooldown", mk(1'b1, 10'd112, 10'd32, 4'b0001, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
